capture_trigger: RTL and testbench

Parametrised trigger and capture sequencer for the logic-analyser instrument. It sits between the sampled input port and the capture FIFO/RAM. It evaluates a configurable multi-bit level/edge trigger and keeps a ring buffer filled with a programmable number of pre-trigger samples. It then writes the post-trigger samples and reports a completed buffer to the SPI controller, which uses that report to read out the buffer and re-arm with "next buffer".

---
 rtl/capture_pkg.sv | 17 +
 rtl/trigger_match.sv | 34 +++
 rtl/capture_trigger.sv | 148 ++++++++++++++
 tb/tb_capture_trigger.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/capture_pkg.sv
// Shared types for the logic-analyser trigger/capture sequencer.
package capture_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StFill  = 3'd1,
    StArmed = 3'd2,
    StPost  = 3'd3,
    StDone  = 3'd4
  } state_e;

  localparam logic [1:0] MODE_LEVEL     = 2'd0;
  localparam logic [1:0] MODE_EDGE      = 2'd1;
  localparam logic [1:0] MODE_BOTH      = 2'd2;
  localparam logic [1:0] MODE_IMMEDIATE = 2'd3;

endpackage

// File: rtl/trigger_match.sv
// Combinational level/edge trigger evaluation on the registered sample pair.
module trigger_match
  import capture_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_sample_q,
  input  logic [WIDTH-1:0] i_sample_qq,
  input  logic [WIDTH-1:0] i_mask,
  input  logic [WIDTH-1:0] i_value,
  input  logic [WIDTH-1:0] i_rise,
  input  logic [WIDTH-1:0] i_fall,
  input  logic [1:0]       i_mode,
  output logic             o_hit
);

  logic w_level;
  logic w_edge;

  assign w_level = (((i_sample_q ^ i_value) & i_mask) == '0);
  assign w_edge  = |((~i_sample_qq & i_sample_q & i_rise) |
                     (i_sample_qq & ~i_sample_q & i_fall));

  always_comb begin
    o_hit = 1'b0;
    case (i_mode)
      MODE_LEVEL: o_hit = w_level;
      MODE_EDGE:  o_hit = w_edge;
      MODE_BOTH:  o_hit = w_level && w_edge;
      default:    o_hit = 1'b1;
    endcase
  end

endmodule

// File: rtl/capture_trigger.sv
// Trigger and capture sequencer: pre-trigger ring fill, trigger search, post-trigger
// fill, then hold the completed buffer until it is released or aborted.
module capture_trigger
  import capture_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [WIDTH-1:0]      i_inport,
  input  logic [WIDTH-1:0]      i_cfg_mask,
  input  logic [WIDTH-1:0]      i_cfg_value,
  input  logic [WIDTH-1:0]      i_cfg_rise,
  input  logic [WIDTH-1:0]      i_cfg_fall,
  input  logic [1:0]            i_cfg_mode,
  input  logic [ADDR_WIDTH-1:0] i_cfg_pretrig,
  input  logic                  i_arm,
  input  logic                  i_abort,
  input  logic                  i_buf_release,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [WIDTH-1:0]      o_wr_data,
  output logic [ADDR_WIDTH-1:0] o_trig_addr,
  output logic [ADDR_WIDTH-1:0] o_start_addr,
  output logic                  o_buf_ready,
  output logic [2:0]            o_state
);

  localparam logic [ADDR_WIDTH-1:0] AddrOne  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] LastAddr = '1;

  state_e                r_state, w_state_d;
  logic [WIDTH-1:0]      r_sample_q, r_sample_qq;
  logic [WIDTH-1:0]      r_mask, r_value, r_rise, r_fall;
  logic [1:0]            r_mode;
  logic [ADDR_WIDTH-1:0] r_pretrig, r_pre_cnt, r_post_cnt;
  logic [ADDR_WIDTH-1:0] r_wr_addr, r_trig_addr, r_start_addr;
  logic                  r_wr_en, r_buf_ready;
  logic                  w_hit, w_latch_cfg, w_capture, w_wr_en_d;

  trigger_match #(
    .WIDTH(WIDTH)
  ) u_trigger_match (
    .i_sample_q (r_sample_q),
    .i_sample_qq(r_sample_qq),
    .i_mask     (r_mask),
    .i_value    (r_value),
    .i_rise     (r_rise),
    .i_fall     (r_fall),
    .i_mode     (r_mode),
    .o_hit      (w_hit)
  );

  always_comb begin
    w_state_d   = r_state;
    w_latch_cfg = 1'b0;
    w_capture   = 1'b0;
    if (i_abort) begin
      w_state_d = StIdle;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_arm) begin
            w_latch_cfg = 1'b1;
            w_state_d   = (i_cfg_pretrig == '0) ? StArmed : StFill;
          end
        end
        StFill: begin
          if ((r_pre_cnt + AddrOne) == r_pretrig) w_state_d = StArmed;
        end
        StArmed: begin
          if (w_hit) begin
            w_capture = 1'b1;
            w_state_d = (r_pretrig == LastAddr) ? StDone : StPost;
          end
        end
        StPost: begin
          if (r_post_cnt == AddrOne) w_state_d = StDone;
        end
        StDone: begin
          // A simultaneous arm is treated as part of the release.
          if (i_buf_release) begin
            w_latch_cfg = 1'b1;
            w_state_d   = (i_cfg_pretrig == '0) ? StArmed : StFill;
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  assign w_wr_en_d = (w_state_d == StFill) || (w_state_d == StArmed) || (w_state_d == StPost);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_sample_q   <= '0;
      r_sample_qq  <= '0;
      r_mask       <= '0;
      r_value      <= '0;
      r_rise       <= '0;
      r_fall       <= '0;
      r_mode       <= '0;
      r_pretrig    <= '0;
      r_pre_cnt    <= '0;
      r_post_cnt   <= '0;
      r_wr_addr    <= '0;
      r_trig_addr  <= '0;
      r_start_addr <= '0;
      r_wr_en      <= 1'b0;
      r_buf_ready  <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_sample_q  <= i_inport;
      r_sample_qq <= r_sample_q;
      r_wr_en     <= w_wr_en_d;
      r_buf_ready <= (w_state_d == StDone);
      if (w_latch_cfg) begin
        r_mask    <= i_cfg_mask;
        r_value   <= i_cfg_value;
        r_rise    <= i_cfg_rise;
        r_fall    <= i_cfg_fall;
        r_mode    <= i_cfg_mode;
        r_pretrig <= i_cfg_pretrig;
      end
      r_pre_cnt <= (r_state == StFill) ? (r_pre_cnt + AddrOne) : '0;
      if (w_capture) begin
        r_post_cnt   <= LastAddr - r_pretrig;
        r_trig_addr  <= r_wr_addr;
        r_start_addr <= r_wr_addr - r_pretrig;
      end else if (r_state == StPost) begin
        r_post_cnt <= r_post_cnt - AddrOne;
      end
      // The address only ever advances; the ring position survives arm and release.
      if (r_wr_en) r_wr_addr <= r_wr_addr + AddrOne;
    end
  end

  assign o_wr_en      = r_wr_en;
  assign o_wr_addr    = r_wr_addr;
  assign o_wr_data    = r_sample_q;
  assign o_trig_addr  = r_trig_addr;
  assign o_start_addr = r_start_addr;
  assign o_buf_ready  = r_buf_ready;
  assign o_state      = r_state;

endmodule

// File: tb/tb_capture_trigger.sv
// Directed self-checking bench for capture_trigger with a counting probe input.
module tb_capture_trigger;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] inport, cfg_mask, cfg_value, cfg_rise, cfg_fall;
  logic [1:0]  cfg_mode;
  logic [4:0]  cfg_pretrig;
  logic        arm, abort, buf_release;
  logic        wr_en, buf_ready;
  logic [4:0]  wr_addr, trig_addr, start_addr;
  logic [15:0] wr_data;
  logic [2:0]  state;

  logic [15:0] mem [32];
  logic [15:0] last_data = '0;
  int          n_writes = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          cycles;
  int          base;

  capture_trigger #(
    .WIDTH(16),
    .ADDR_WIDTH(5)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_inport     (inport),
    .i_cfg_mask   (cfg_mask),
    .i_cfg_value  (cfg_value),
    .i_cfg_rise   (cfg_rise),
    .i_cfg_fall   (cfg_fall),
    .i_cfg_mode   (cfg_mode),
    .i_cfg_pretrig(cfg_pretrig),
    .i_arm        (arm),
    .i_abort      (abort),
    .i_buf_release(buf_release),
    .o_wr_en      (wr_en),
    .o_wr_addr    (wr_addr),
    .o_wr_data    (wr_data),
    .o_trig_addr  (trig_addr),
    .o_start_addr (start_addr),
    .o_buf_ready  (buf_ready),
    .o_state      (state)
  );

  always #5 clk = ~clk;

  // Buffer model: records every write the DUT issues.
  always @(negedge clk) begin
    if (wr_en) begin
      mem[wr_addr] = wr_data;
      last_data    = wr_data;
      n_writes     = n_writes + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    inport = inport + 16'h1;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (!buf_ready && n < budget) begin
      tick();
      n = n + 1;
    end
    if (!buf_ready) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic set_cfg(input logic [1:0] mode, input logic [15:0] mask, input logic [15:0] value,
                         input logic [15:0] rise, input logic [4:0] pre);
    cfg_mode    = mode;
    cfg_mask    = mask;
    cfg_value   = value;
    cfg_rise    = rise;
    cfg_fall    = 16'h0;
    cfg_pretrig = pre;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; inport = '0; arm = 1'b0; abort = 1'b0; buf_release = 1'b0;
    set_cfg(2'd0, 16'h0, 16'h0, 16'h0, 5'd0);
    tick(); tick();
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_trig_addr", trig_addr, 0);
    check("rst_start_addr", start_addr, 0);
    check("rst_buf_ready", buf_ready, 0);
    check("rst_state", state, 0);
    rst_n = 1'b1;
    tick(); tick();
    check("idle_no_write", wr_en, 0);

    // Rising edge on bit 3, 8 pre-trigger samples; cfg changes mid-capture are ignored.
    set_cfg(2'd1, 16'h0, 16'h0, 16'h0008, 5'd8);
    inport = 16'h0; arm = 1'b1; base = n_writes;
    tick();
    arm = 1'b0;
    check("t1_first_wr_en", wr_en, 1);
    check("t1_first_data", wr_data, 16'h0000);
    check("t1_state_fill", state, 1);
    set_cfg(2'd3, 16'h0, 16'h0, 16'h0001, 5'd0);
    wait_done(100, cycles);
    check("t1_cycles", cycles, 32);
    check("t1_writes", n_writes - base, 32);
    check("t1_trig_addr", trig_addr, 8);
    check("t1_start_addr", start_addr, 0);
    check("t1_trig_sample", mem[trig_addr], 16'h0008);
    check("t1_last_data", last_data, 16'h001F);
    check("t1_state_done", state, 4);
    check("t1_wr_en_done", wr_en, 0);

    // Level match on low byte, no pre-trigger samples.
    do_abort();
    check("t2_abort_ready", buf_ready, 0);
    check("t2_abort_state", state, 0);
    set_cfg(2'd0, 16'h00FF, 16'h0042, 16'h0, 5'd0);
    inport = 16'h0; arm = 1'b1; base = n_writes;
    tick();
    arm = 1'b0;
    check("t2_state_armed", state, 2);
    wait_done(200, cycles);
    check("t2_writes", n_writes - base, 98);
    check("t2_trig_addr", trig_addr, 2);
    check("t2_start_addr", start_addr, 2);
    check("t2_trig_sample", mem[trig_addr], 16'h0042);
    check("t2_last_data", last_data, 16'h0061);

    // Immediate trigger with a full pre-trigger window.
    do_abort();
    set_cfg(2'd3, 16'h0, 16'h0, 16'h0, 5'd31);
    inport = 16'h0; arm = 1'b1; base = n_writes;
    tick();
    arm = 1'b0;
    wait_done(100, cycles);
    check("t3_cycles", cycles, 32);
    check("t3_writes", n_writes - base, 32);
    check("t3_trig_addr", trig_addr, 1);
    check("t3_start_addr", start_addr, 2);
    check("t3_trig_sample", mem[trig_addr], 16'h001F);

    // Abort while in POST.
    do_abort();
    set_cfg(2'd3, 16'h0, 16'h0, 16'h0, 5'd0);
    inport = 16'h0; arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
    check("t4_state_post", state, 3);
    check("t4_trig_addr", trig_addr, 2);
    tick();
    do_abort();
    check("t4_abort_wr_en", wr_en, 0);
    check("t4_abort_state", state, 0);
    check("t4_abort_ready", buf_ready, 0);
    check("t4_abort_addr", wr_addr, 5);
    tick(); tick();
    check("t4_idle_addr", wr_addr, 5);
    check("t4_idle_ready", buf_ready, 0);
    set_cfg(2'd3, 16'h0, 16'h0, 16'h0, 5'd4);
    inport = 16'h0; arm = 1'b1;
    tick();
    arm = 1'b0;
    check("t4_rearm_addr", wr_addr, 5);
    check("t4_rearm_wr_en", wr_en, 1);
    wait_done(100, cycles);
    check("t4_trig_addr2", trig_addr, 9);
    check("t4_start_addr2", start_addr, 5);

    // Release together with arm in DONE: acts as release with new config.
    set_cfg(2'd1, 16'h0, 16'h0, 16'h0010, 5'd2);
    inport = 16'h0; arm = 1'b1; buf_release = 1'b1; base = n_writes;
    tick();
    arm = 1'b0; buf_release = 1'b0;
    check("t5_state_fill", state, 1);
    check("t5_ready_clear", buf_ready, 0);
    check("t5_wr_addr", wr_addr, 5);
    check("t5_wr_en", wr_en, 1);
    wait_done(100, cycles);
    check("t5_cycles", cycles, 46);
    check("t5_writes", n_writes - base, 46);
    check("t5_trig_addr", trig_addr, 21);
    check("t5_start_addr", start_addr, 19);
    check("t5_trig_sample", mem[trig_addr], 16'h0010);
    check("t5_last_data", last_data, 16'h002D);
    check("t5_ready", buf_ready, 1);
    check("t5_end_addr", wr_addr, 19);

    // Asynchronous reset asserted mid-POST.
    set_cfg(2'd3, 16'h0, 16'h0, 16'h0, 5'd0);
    buf_release = 1'b1;
    tick();
    buf_release = 1'b0;
    tick(); tick();
    check("t6_state_post", state, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_wr_en", wr_en, 0);
    check("t6_rst_wr_addr", wr_addr, 0);
    check("t6_rst_trig", trig_addr, 0);
    check("t6_rst_start", start_addr, 0);
    check("t6_rst_state", state, 0);
    check("t6_rst_ready", buf_ready, 0);
    check("t6_rst_data", wr_data, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    check("t6_after_state", state, 0);
    check("t6_after_wr_en", wr_en, 0);
    check("t6_after_addr", wr_addr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
